// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two small per-source FIFOs (A = ALU/EX, B = load/MEM)
// share the single regfile write port through a round-robin grant. The write
// request is registered; q_hit reports any write still pending in this block.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              w_req,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic              idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NS = 2;  // index 0 = source A, index 1 = source B
  localparam logic [PW:0] PTR_ONE = 1;

  logic [NS-1:0]     in_valid;
  logic [ADDR_W-1:0] in_addr [NS];
  logic [DATA_W-1:0] in_data [NS];
  logic [NS-1:0]     fifo_full;
  logic [NS-1:0]     fifo_empty;
  logic [NS-1:0]     src_ready;
  logic [NS-1:0]     src_hit;
  logic [NS-1:0]     pop;
  logic [ADDR_W-1:0] head_addr [NS];
  logic [DATA_W-1:0] head_data [NS];

  logic              w_req_q, w_req_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              last_b_q, last_b_d;

  assign in_valid   = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_fifo
      logic [ADDR_W-1:0]     addr_mem [FIFO_DEPTH];
      logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
      logic [PW:0]           wr_ptr_q, wr_ptr_d;
      logic [PW:0]           rd_ptr_q, rd_ptr_d;
      logic [PW:0]           count;
      logic [FIFO_DEPTH-1:0] slot_hit;
      logic                  push;

      // Wrap bit differs while index bits match -> full; identical -> empty.
      assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
      assign fifo_full[gi]  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                              (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      assign src_ready[gi]  = rdy & ~rst & ~fifo_full[gi];
      // Writes to x0 complete the handshake but are never queued.
      assign push           = in_valid[gi] & src_ready[gi] & (in_addr[gi] != '0);
      assign count          = wr_ptr_q - rd_ptr_q;
      assign head_addr[gi]  = addr_mem[rd_ptr_q[PW-1:0]];
      assign head_data[gi]  = data_mem[rd_ptr_q[PW-1:0]];

      // Advance pointers on push/pop; both in one cycle leaves the count unchanged.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push)    wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop[gi]) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // Pointer registers; reset empties the FIFO.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      // Entry storage, written at the tail on an accepted push.
      always_ff @(posedge clk) begin
        if (push) begin
          addr_mem[wr_ptr_q[PW-1:0]] <= in_addr[gi];
          data_mem[wr_ptr_q[PW-1:0]] <= in_data[gi];
        end
      end

      // A slot is live when its distance from the read pointer is below the count.
      for (genvar si = 0; si < FIFO_DEPTH; si++) begin : g_slot
        localparam logic [PW-1:0] SLOT = PW'(si);
        logic [PW-1:0] offset;
        assign offset       = SLOT - rd_ptr_q[PW-1:0];
        assign slot_hit[si] = ({1'b0, offset} < count) && (addr_mem[si] == q_addr);
      end

      assign src_hit[gi] = |slot_hit;
    end
  endgenerate

  // Round-robin grant: when both sources wait, the one not granted last wins.
  always_comb begin
    pop = '0;
    if (rdy && !rst) begin
      if (!fifo_empty[0] && (fifo_empty[1] || last_b_q)) pop[0] = 1'b1;
      else if (!fifo_empty[1])                           pop[1] = 1'b1;
    end
  end

  // Next write-port state: load the popped entry; hold everything while frozen.
  always_comb begin
    w_req_d  = w_req_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    last_b_d = last_b_q;
    if (rdy) begin
      w_req_d = |pop;
      if (pop[0]) begin
        w_addr_d = head_addr[0];
        w_data_d = head_data[0];
        last_b_d = 1'b0;
      end else if (pop[1]) begin
        w_addr_d = head_addr[1];
        w_data_d = head_data[1];
        last_b_d = 1'b1;
      end
    end
  end

  // Write-port and round-robin registers; reset makes A the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_req_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      last_b_q <= 1'b1;
    end else begin
      w_req_q  <= w_req_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      last_b_q <= last_b_d;
    end
  end

  assign a_ready = src_ready[0];
  assign b_ready = src_ready[1];
  assign w_req   = w_req_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;
  assign q_hit   = ~rst & (q_addr != '0) &
                   ((|src_hit) | (w_req_q & (w_addr_q == q_addr)));
  assign idle    = (&fifo_empty) & ~w_req_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, q_addr;
  logic [DW-1:0] a_data, b_data;
  logic          w_req, q_hit, idle;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
    .q_addr(q_addr), .q_hit(q_hit), .idle(idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW-1:0] qa_addr[$], qb_addr[$];
  logic [DW-1:0] qa_data[$], qb_data[$];
  logic          m_w_req;
  logic [AW-1:0] m_w_addr;
  logic [DW-1:0] m_w_data;
  bit            m_last_b;
  bit            m_on = 0;
  bit            log_en = 0;
  logic [AW-1:0] commit_log[$];

  task automatic model_step();
    bit push_a, push_b;
    push_a = a_valid && rdy && !rst && qa_addr.size() < D && a_addr != 0;
    push_b = b_valid && rdy && !rst && qb_addr.size() < D && b_addr != 0;
    if (rst) begin
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
      m_w_req = 0; m_w_addr = '0; m_w_data = '0; m_last_b = 1; m_on = 1;
    end else if (rdy) begin
      if (qa_addr.size() > 0 && (qb_addr.size() == 0 || m_last_b)) begin
        m_w_req = 1; m_w_addr = qa_addr.pop_front(); m_w_data = qa_data.pop_front(); m_last_b = 0;
      end else if (qb_addr.size() > 0) begin
        m_w_req = 1; m_w_addr = qb_addr.pop_front(); m_w_data = qb_data.pop_front(); m_last_b = 1;
      end else begin
        m_w_req = 0;
      end
      if (push_a) begin qa_addr.push_back(a_addr); qa_data.push_back(a_data); end
      if (push_b) begin qb_addr.push_back(b_addr); qb_data.push_back(b_data); end
    end
  endtask

  function automatic bit model_hit();
    bit h = 0;
    if (rst || q_addr == 0) return 0;
    foreach (qa_addr[i]) if (qa_addr[i] == q_addr) h = 1;
    foreach (qb_addr[i]) if (qb_addr[i] == q_addr) h = 1;
    if (m_w_req && m_w_addr == q_addr) h = 1;
    return h;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("a_ready", a_ready, rdy && !rst && qa_addr.size() < D);
      chk("b_ready", b_ready, rdy && !rst && qb_addr.size() < D);
      chk("w_req", w_req, m_w_req);
      chk("w_addr", w_addr, m_w_addr);
      chk("w_data", w_data, m_w_data);
      chk("idle", idle, qa_addr.size() == 0 && qb_addr.size() == 0 && !m_w_req);
      chk("q_hit", q_hit, model_hit());
      if (log_en && w_req && rdy) commit_log.push_back(w_addr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int ia, ib, guard;
    bit acc_a, acc_b;
    logic [AW-1:0] exp_addr;

    rst = 1; rdy = 1; a_valid = 0; b_valid = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; q_addr = '0;
    step(); step();
    chk("rst_w_req", w_req, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    rst = 0; #1;
    chk("a_ready_after_rst", a_ready, 1);

    // Single A push, no bypass
    a_valid = 1; a_addr = 5; a_data = 32'hDEAD;
    step();
    a_valid = 0;
    chk("t1_no_bypass", w_req, 0);
    step();
    chk("t1_w_req", w_req, 1);
    chk("t1_w_addr", w_addr, 5);
    chk("t1_w_data", w_data, 32'hDEAD);
    step();
    chk("t1_w_req_drop", w_req, 0);
    chk("t1_idle", idle, 1);

    // Both sources saturated: strict alternation starting with A
    do_reset();
    ia = 0; ib = 0; guard = 0; log_en = 1;
    while ((ia < 8 || ib < 8) && guard < 200) begin
      a_valid = (ia < 8); a_addr = AW'(9 + ia); a_data = 32'hA0 + ia;
      b_valid = (ib < 8); b_addr = AW'(1 + ib); b_data = 32'hB0 + ib;
      #3;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      step();
      if (acc_a) ia++;
      if (acc_b) ib++;
      guard++;
    end
    chk("t2_all_pushed", guard < 200, 1);
    a_valid = 0; b_valid = 0;
    repeat (8) step();
    log_en = 0;
    chk("t2_log_len", commit_log.size(), 16);
    for (int i = 0; i < 16; i++) begin
      exp_addr = (i % 2 == 0) ? AW'(9 + i / 2) : AW'(1 + i / 2);
      chk($sformatf("t2_order_%0d", i), (i < commit_log.size()) ? commit_log[i] : 'x, exp_addr);
    end

    // Fill A while B takes its turn
    do_reset();
    a_valid = 1; a_addr = 20; a_data = 20; b_valid = 1; b_addr = 21; b_data = 21;
    step();
    a_addr = 22; a_data = 22; b_addr = 23; b_data = 23;
    step();
    a_addr = 24; a_data = 24; b_valid = 0;
    #1;
    chk("t3_a_ready_pre", a_ready, 1);
    step();
    a_valid = 0;
    chk("t3_a_full", a_ready, 0);
    chk("t3_b_grant", w_addr, 21);
    step();
    chk("t3_a_pop", w_addr, 22);
    chk("t3_a_ready_back", a_ready, 1);
    repeat (4) step();

    // Discarded x0 write, then q_hit lifetime
    b_valid = 1; b_addr = 0; b_data = 32'h1234;
    #1;
    chk("t4_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    repeat (3) begin
      chk("t4_no_write", w_req, 0);
      chk("t4_idle", idle, 1);
      step();
    end
    q_addr = 3; a_valid = 1; a_addr = 3; a_data = 33;
    #1;
    chk("t4_hit_before", q_hit, 0);
    step();
    a_valid = 0;
    chk("t4_hit_queued", q_hit, 1);
    step();
    chk("t4_w_req", w_req, 1);
    chk("t4_hit_writing", q_hit, 1);
    step();
    chk("t4_w_req_drop", w_req, 0);
    chk("t4_hit_cleared", q_hit, 0);

    // Freeze with a write on the port
    a_valid = 1; a_addr = 7; a_data = 77;
    step();
    a_valid = 0;
    step();
    chk("t5_w_addr", w_addr, 7);
    rdy = 0; a_valid = 1; a_addr = 8; a_data = 88;
    #1;
    chk("t5_a_ready_frozen", a_ready, 0);
    repeat (3) begin
      step();
      chk("t5_w_req_held", w_req, 1);
      chk("t5_w_addr_held", w_addr, 7);
      chk("t5_w_data_held", w_data, 77);
    end
    rdy = 1;
    #1;
    chk("t5_a_ready_resume", a_ready, 1);
    step();
    a_valid = 0;
    chk("t5_after_commit", w_req, 0);
    step();
    chk("t5_next_req", w_req, 1);
    chk("t5_next_addr", w_addr, 8);
    chk("t5_next_data", w_data, 88);
    repeat (2) step();

    // Reset with queued writes
    a_valid = 1; a_addr = 10; a_data = 10; b_valid = 1; b_addr = 11; b_data = 11;
    step();
    a_addr = 12; a_data = 12; b_addr = 13; b_data = 13;
    step();
    a_addr = 14; a_data = 14; b_valid = 0;
    step();
    a_valid = 0;
    chk("t6_busy", idle, 0);
    rst = 1;
    step();
    rst = 0;
    chk("t6_w_req", w_req, 0);
    chk("t6_w_addr", w_addr, 0);
    chk("t6_w_data", w_data, 0);
    chk("t6_idle", idle, 1);
    repeat (4) begin
      step();
      chk("t6_no_write", w_req, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
